// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: multi-cycle RV32M multiply/divide engine for the EX stage.
// It accepts one op through a valid/ready handshake. It computes one bit per
// cycle (shift-add multiply, restoring divide). It returns the result and the
// destination tag through a second valid/ready handshake.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   flush             abort the in-flight op (branch redirect)
//   in_valid/in_ready op request handshake; in_ready is high only in IDLE
//   in_funct3         RV32M funct3 (MUL..REMU)
//   in_rs1, in_rs2    operands A (multiplicand/dividend), B (multiplier/divisor)
//   in_rd             destination tag carried with the op
//   out_valid/ready   result handshake; result and tag held until taken
//   out_result,out_rd result and its tag
//   busy              unit is not IDLE
//
// Optional feature: define MULDIV_FAST_MUL_EN to compute MUL* in one cycle.
module rv_muldiv_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_rd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_rd,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam int unsigned PW    = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PW-1:0]    acc_q, acc_d;       // MUL: product; DIV: {remainder, dividend/quotient}
  logic [PW-1:0]    opb_q, opb_d;       // MUL: shifted multiplicand; DIV: divisor in low half
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic             res_lo_q, res_lo_d;     // MUL returns low half
  logic             res_rem_q, res_rem_d;   // REM/REMU returns remainder
  logic             b_signed_q, b_signed_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             special_q, special_d;   // divide result already final in acc low half
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_result_q, out_result_d;
  logic [TAG_W-1:0] out_rd_q, out_rd_d;

  logic             div_signed, mul_a_signed, mul_b_signed;
  logic             a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0]  a_mag, b_mag, quo, rem;
  logic [XLEN:0]    diff;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [PW+1:0] fast_prod;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      acc_q        <= '0;
      opb_q        <= '0;
      mplier_q     <= '0;
      rd_q         <= '0;
      res_lo_q     <= 1'b0;
      res_rem_q    <= 1'b0;
      b_signed_q   <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      special_q    <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      acc_q        <= acc_d;
      opb_q        <= opb_d;
      mplier_q     <= mplier_d;
      rd_q         <= rd_d;
      res_lo_q     <= res_lo_d;
      res_rem_q    <= res_rem_d;
      b_signed_q   <= b_signed_d;
      q_neg_q      <= q_neg_d;
      r_neg_q      <= r_neg_d;
      special_q    <= special_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
    end
  end

  // Next-state, iteration datapath and output decode
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    acc_d        = acc_q;
    opb_d        = opb_q;
    mplier_d     = mplier_q;
    rd_d         = rd_q;
    res_lo_d     = res_lo_q;
    res_rem_d    = res_rem_q;
    b_signed_d   = b_signed_q;
    q_neg_d      = q_neg_q;
    r_neg_d      = r_neg_q;
    special_d    = special_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;

    // Operand decode for the accept cycle
    div_signed   = !in_funct3[0];
    mul_a_signed = (in_funct3[1:0] == 2'b01) || (in_funct3[1:0] == 2'b10);
    mul_b_signed = (in_funct3[1:0] == 2'b01);
    a_neg        = div_signed && in_rs1[XLEN-1];
    b_neg        = div_signed && in_rs2[XLEN-1];
    a_mag        = a_neg ? -in_rs1 : in_rs1;
    b_mag        = b_neg ? -in_rs2 : in_rs2;
    div_zero     = (in_rs2 == '0);
    div_ovf      = div_signed && (in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (in_rs2 == '1);
`ifdef MULDIV_FAST_MUL_EN
    fast_prod    = $signed({in_rs1[XLEN-1] & mul_a_signed, in_rs1}) *
                   $signed({in_rs2[XLEN-1] & mul_b_signed, in_rs2});
`endif

    // Restoring step: shift {rem, dividend msb} and trial-subtract the divisor
    diff = acc_q[PW-1:XLEN-1] - {1'b0, opb_q[XLEN-1:0]};
    quo  = acc_q[XLEN-1:0];
    rem  = acc_q[PW-1:XLEN];

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && !flush) begin
          rd_d      = in_rd;
          res_lo_d  = (in_funct3 == 3'b000);
          res_rem_d = in_funct3[1];
          special_d = 1'b0;
          if (in_funct3[2]) begin
            state_d = S_DIV;
            count_d = CNT_W'(XLEN);
            acc_d   = {{XLEN{1'b0}}, a_mag};
            opb_d   = {{XLEN{1'b0}}, b_mag};
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            // Special cases skip iteration: count 0 reaches DONE on the next edge
            if (div_zero) begin
              special_d = 1'b1;
              count_d   = '0;
              acc_d     = {{XLEN{1'b0}}, (in_funct3[1] ? in_rs1 : {XLEN{1'b1}})};
            end else if (div_ovf) begin
              special_d = 1'b1;
              count_d   = '0;
              acc_d     = {{XLEN{1'b0}}, (in_funct3[1] ? {XLEN{1'b0}} : in_rs1)};
            end
          end else begin
            state_d    = S_MUL;
            b_signed_d = mul_b_signed;
            mplier_d   = in_rs2;
            opb_d      = {{XLEN{in_rs1[XLEN-1] & mul_a_signed}}, in_rs1};
`ifdef MULDIV_FAST_MUL_EN
            acc_d      = fast_prod[PW-1:0];
            count_d    = '0;
`else
            acc_d      = '0;
            count_d    = CNT_W'(XLEN);
`endif
          end
        end
      end
      S_MUL: begin
        if (count_q == '0) begin
          state_d      = S_DONE;
          out_result_d = res_lo_q ? acc_q[XLEN-1:0] : acc_q[PW-1:XLEN];
          out_rd_d     = rd_q;
        end else begin
          // A signed multiplier's top bit carries weight -2^(XLEN-1)
          if (mplier_q[0]) begin
            acc_d = (b_signed_q && (count_q == CNT_W'(1))) ? (acc_q - opb_q) : (acc_q + opb_q);
          end
          opb_d    = {opb_q[PW-2:0], 1'b0};
          mplier_d = {1'b0, mplier_q[XLEN-1:1]};
          count_d  = count_q - CNT_W'(1);
        end
      end
      S_DIV: begin
        if (count_q == '0) begin
          state_d  = S_DONE;
          out_rd_d = rd_q;
          if (special_q) begin
            out_result_d = quo;
          end else if (res_rem_q) begin
            out_result_d = r_neg_q ? -rem : rem;
          end else begin
            out_result_d = q_neg_q ? -quo : quo;
          end
        end else begin
          if (!diff[XLEN]) begin
            acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {acc_q[PW-2:0], 1'b0};
          end
          count_d = count_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end

    in_ready_d  = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_rd     = out_rd_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
  localparam int LAT_DIV = 33;
`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  typedef struct packed {
    logic [XLEN-1:0]  res;
    logic [TAG_W-1:0] rd;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_funct3;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [TAG_W-1:0] in_rd;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_result;
  logic [TAG_W-1:0] out_rd;
  logic             busy;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  rv_muldiv_unit #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_funct3  (in_funct3),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0]        pu;
    logic signed [63:0] sa, sb, ps;
    logic               ovf;
    logic [31:0]        r;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    pu  = {32'b0, a} * {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: r = pu[31:0];
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * $signed({32'b0, b}); r = ps[63:32]; end
      3'd3: r = pu[63:32];
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return LAT_MUL;
    if (b == 0) return 1;
    if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT_DIV;
  endfunction

  // Present one op and let the accepting edge pass; optionally scoreboard it
  task automatic start_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input bit push);
    int w;
    exp_t e;
    w = 0;
    while (in_ready !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    if (w >= 100) check({tag, "_ready_timeout"}, 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_funct3 = f;
    in_rs1    = a;
    in_rs2    = b;
    in_rd     = rd;
    if (push) begin
      e.res = exp;
      e.rd  = rd;
      sb_q.push_back(e);
    end
    tick();
    in_valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
  endtask

  // Wait for the result, check latency, optionally stall the consumer, then take it
  task automatic await_op(input string tag, input int lat, input int hold);
    int   n;
    exp_t e;
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'b1;
      in_funct3 = 3'd5;
      in_rs1    = $urandom;
      in_rs2    = 32'd3;
      in_rd     = 5'd31;
      tick();
      check($sformatf("%s_hold%0d_valid", tag, i), 64'(out_valid), 64'd1);
      check($sformatf("%s_hold%0d_result", tag, i), 64'(out_result), 64'(e.res));
      check($sformatf("%s_hold%0d_rd", tag, i), 64'(out_rd), 64'(e.rd));
      check($sformatf("%s_hold%0d_in_ready", tag, i), 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    check({tag, "_result"}, 64'(out_result), 64'(e.res));
    check({tag, "_rd"}, 64'(out_rd), 64'(e.rd));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    start_op(tag, f, a, b, rd, exp, 1'b1);
    await_op(tag, exp_lat(f, a, b), 0);
  endtask

  task automatic expect_no_result(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    check({tag, "_no_out_valid"}, 64'(seen), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_result"}, 64'(out_result), 64'd0);
    check({tag, "_out_rd"}, 64'(out_rd), 64'd0);
  endtask

  initial begin
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_funct3 = 3'd0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_rd     = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check_reset_state("por");
    reset = 1'b0;
    tick();

    // Multiply
    run_op("mul",    3'd0, 32'd7,          32'hFFFF_FFFD, 5'd9,  32'hFFFF_FFEB);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd11, 32'h0000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF,  32'd2,         5'd12, 32'hFFFF_FFFF);

    // Divide
    run_op("div",    3'd4, 32'hFFFF_FFF9,  32'd2,         5'd13, 32'hFFFF_FFFD);
    run_op("rem",    3'd6, 32'hFFFF_FFF9,  32'd2,         5'd14, 32'hFFFF_FFFF);
    run_op("divu",   3'd5, 32'd100,        32'd7,         5'd15, 32'd14);
    run_op("remu",   3'd7, 32'd100,        32'd7,         5'd16, 32'd2);

    // Special cases resolve in one edge
    run_op("divu0",  3'd5, 32'd5,          32'd0,         5'd17, 32'hFFFF_FFFF);
    run_op("remu0",  3'd7, 32'd5,          32'd0,         5'd18, 32'd5);
    run_op("divovf", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd19, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd20, 32'h0);

    // Consumer stall: result and tag held, no new op accepted
    start_op("stall", 3'd0, 32'd1234, 32'd5678, 5'd21, 32'd7006652, 1'b1);
    await_op("stall", LAT_MUL, 10);

    // Flush mid-divide
    start_op("flush", 3'd4, 32'd1000, 32'd3, 5'd22, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    expect_no_result("flush", 40);

    // Flush in the same cycle as a request: not accepted
    in_valid  = 1'b1;
    in_funct3 = 3'd5;
    in_rs1    = 32'd9;
    in_rs2    = 32'd3;
    in_rd     = 5'd23;
    flush     = 1'b1;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_req_busy", 64'(busy), 64'd0);
    check("flush_req_in_ready", 64'(in_ready), 64'd1);
    expect_no_result("flush_req", 40);

    // Reset mid-multiply
    start_op("rstmul", 3'd0, 32'd3, 32'd5, 5'd24, 32'd0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rstmul");
    expect_no_result("rstmul", 40);

    // Mixed ops against the reference model
    for (int i = 0; i < 10; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      case (i % 5)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 255));
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb, 5'(i + 1), model(rf, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
